// File: rtl/wrb_port_arbiter.sv
// Regfile write-port arbiter: in-order pipe result wins, divider results queue in a pending FIFO.
// Optional macro WRB_ARB_BYPASS_EN lets an idle-port divider result skip the FIFO.
module wrb_port_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_valid_i,
    input  logic [4:0]      pipe_rd_addr_i,
    input  logic [XLEN-1:0] pipe_rd_data_i,
    output logic            pipe_stall_o,
    input  logic            div_valid_i,
    output logic            div_ready_o,
    input  logic [4:0]      div_rd_addr_i,
    input  logic [XLEN-1:0] div_rd_data_i,
    output logic            rf_wr_en_o,
    output logic [4:0]      rf_wr_addr_o,
    output logic [XLEN-1:0] rf_wr_data_o,
    output logic [31:0]     pend_mask_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_FORCE} state_t;

    state_t             state, state_nxt;
    logic [4:0]         q_addr [DEPTH];
    logic [XLEN-1:0]    q_data [DEPTH];
    logic [DEPTH-1:0]   q_live;
    logic [PW-1:0]      rd_ptr, wr_ptr;
    logic [PW:0]        count, count_nxt;
    logic [CW-1:0]      starve_cnt, starve_cnt_nxt;

    logic full, pipe_req, head_live, head_dead, head_kill;
    logic accept, div_keep, bypass, push, pop, pop_write, waiting;
    logic            wr_en_nxt;
    logic [4:0]      wr_addr_nxt;
    logic [XLEN-1:0] wr_data_nxt;

    assign full      = (count == (PW+1)'(DEPTH));
    // The stage is frozen during a forced drain, so its request is not real that cycle.
    assign pipe_req  = pipe_valid_i && (pipe_rd_addr_i != 5'd0) && (state != ST_FORCE);
    assign head_live = (count != '0) && q_live[rd_ptr];
    assign head_dead = (count != '0) && !q_live[rd_ptr];
    assign head_kill = pipe_req && head_live && (q_addr[rd_ptr] == pipe_rd_addr_i);

    assign accept   = div_valid_i && div_ready_o;
    assign div_keep = accept && (div_rd_addr_i != 5'd0)
                      && !(pipe_req && (div_rd_addr_i == pipe_rd_addr_i));
`ifdef WRB_ARB_BYPASS_EN
    assign bypass = div_keep && (state == ST_IDLE) && !pipe_req;
`else
    assign bypass = 1'b0;
`endif
    assign push = div_keep && !bypass;

    assign pop_write = (state == ST_FORCE) || ((state == ST_PEND) && head_live && !pipe_req);
    assign pop       = pop_write || ((state == ST_PEND) && head_dead);
    assign waiting   = (state == ST_PEND) && head_live && pipe_req && !head_kill;

    assign count_nxt = count + (PW+1)'(push) - (PW+1)'(pop);

    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (pop)
            starve_cnt_nxt = '0;
        else if (waiting)
            starve_cnt_nxt = starve_cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (push) state_nxt = ST_PEND;
            ST_PEND: begin
                if (waiting && (starve_cnt + CW'(1) == CW'(STARVE_MAX)))
                    state_nxt = ST_FORCE;
                else if (count_nxt == '0)
                    state_nxt = ST_IDLE;
            end
            ST_FORCE: state_nxt = (count_nxt == '0) ? ST_IDLE : ST_PEND;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pipe_stall_o = (state == ST_FORCE);
        div_ready_o  = !full;
    end

    always_comb begin
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = '0;
        wr_data_nxt = '0;
        if (pop_write) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = q_addr[rd_ptr];
            wr_data_nxt = q_data[rd_ptr];
        end else if (pipe_req) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = pipe_rd_addr_i;
            wr_data_nxt = pipe_rd_data_i;
        end else if (bypass) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = div_rd_addr_i;
            wr_data_nxt = div_rd_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_en_o   <= 1'b0;
            rf_wr_addr_o <= '0;
            rf_wr_data_o <= '0;
        end else begin
            rf_wr_en_o <= wr_en_nxt;
            if (wr_en_nxt) begin
                rf_wr_addr_o <= wr_addr_nxt;
                rf_wr_data_o <= wr_data_nxt;
            end
        end
    end

    // Killed entries stay in place with live cleared and are popped silently later.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_live     <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            count      <= count_nxt;
            starve_cnt <= starve_cnt_nxt;
            if (pipe_req) begin
                for (int unsigned i = 0; i < DEPTH; i++)
                    if (q_addr[i] == pipe_rd_addr_i)
                        q_live[i] <= 1'b0;
            end
            if (pop) begin
                q_live[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + PW'(1);
            end
            if (push) begin
                q_addr[wr_ptr] <= div_rd_addr_i;
                q_data[wr_ptr] <= div_rd_data_i;
                q_live[wr_ptr] <= 1'b1;
                wr_ptr         <= wr_ptr + PW'(1);
            end
        end
    end

    always_comb begin
        pend_mask_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            if (q_live[i])
                pend_mask_o[q_addr[i]] = 1'b1;
    end

endmodule

// File: tb/tb_wrb_port_arbiter.sv
// Randomised bench for wrb_port_arbiter against a queue-based model of the arbitration rules.
// Honours WRB_ARB_BYPASS_EN the same way as the design.
module tb_wrb_port_arbiter;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned DEPTH      = 2;
    localparam int unsigned STARVE_MAX = 4;
`ifdef WRB_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            pipe_valid;
    logic [4:0]      pipe_rd_addr;
    logic [XLEN-1:0] pipe_rd_data;
    logic            pipe_stall;
    logic            div_valid;
    logic            div_ready;
    logic [4:0]      div_rd_addr;
    logic [XLEN-1:0] div_rd_data;
    logic            rf_wr_en;
    logic [4:0]      rf_wr_addr;
    logic [XLEN-1:0] rf_wr_data;
    logic [31:0]     pend_mask;

    wrb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid_i(pipe_valid), .pipe_rd_addr_i(pipe_rd_addr), .pipe_rd_data_i(pipe_rd_data),
        .pipe_stall_o(pipe_stall),
        .div_valid_i(div_valid), .div_ready_o(div_ready),
        .div_rd_addr_i(div_rd_addr), .div_rd_data_i(div_rd_data),
        .rf_wr_en_o(rf_wr_en), .rf_wr_addr_o(rf_wr_addr), .rf_wr_data_o(rf_wr_data),
        .pend_mask_o(pend_mask)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Model: queue of pending results in arrival order; killed entries linger until popped.
    typedef struct {
        logic [4:0]      a;
        logic [XLEN-1:0] d;
        bit              live;
    } ent_t;

    ent_t q[$];
    int   wait_cnt;
    bit   forcing;
    bit   last_stall;
    logic [4:0] watch_addr = 5'd0;
    int   watch_hits;
    logic [XLEN-1:0] watch_data;
    int   ready_low_seen;

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (q[i]) if (q[i].live) m[q[i].a] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        q.delete();
        wait_cnt = 0;
        forcing  = 1'b0;
    endtask

    task automatic step();
        bit preq, acc, empty0, was_force, nforce, e_en;
        logic [4:0]      e_a;
        logic [XLEN-1:0] e_d;
        check_eq("stall", 64'(pipe_stall), 64'(forcing));
        check_eq("ready", 64'(div_ready), 64'(q.size() < DEPTH));
        check_eq("pend_mask", 64'(pend_mask), 64'(model_mask()));
        if (!div_ready) ready_low_seen++;

        was_force = forcing;
        nforce = 1'b0;
        preq   = !forcing && pipe_valid && (pipe_rd_addr != 5'd0);
        acc    = div_valid && (q.size() < DEPTH);
        empty0 = (q.size() == 0);
        e_en = 1'b0; e_a = '0; e_d = '0;
        if (forcing) begin
            e_en = 1'b1; e_a = q[0].a; e_d = q[0].d;
            void'(q.pop_front());
            wait_cnt = 0;
        end else begin
            if (q.size() > 0) begin
                if (!q[0].live) begin
                    void'(q.pop_front());
                    wait_cnt = 0;
                end else if (!preq) begin
                    e_en = 1'b1; e_a = q[0].a; e_d = q[0].d;
                    void'(q.pop_front());
                    wait_cnt = 0;
                end else if (q[0].a != pipe_rd_addr) begin
                    wait_cnt++;
                    if (wait_cnt == STARVE_MAX) nforce = 1'b1;
                end
            end
            if (preq) begin
                e_en = 1'b1; e_a = pipe_rd_addr; e_d = pipe_rd_data;
                foreach (q[i]) if (q[i].a == pipe_rd_addr) q[i].live = 1'b0;
            end
        end
        if (acc && div_rd_addr != 5'd0 && !(preq && div_rd_addr == pipe_rd_addr)) begin
            if (BYP && empty0 && !was_force && !preq) begin
                e_en = 1'b1; e_a = div_rd_addr; e_d = div_rd_data;
            end else begin
                q.push_back('{a: div_rd_addr, d: div_rd_data, live: 1'b1});
            end
        end
        forcing = nforce;

        @(posedge clk);
        #1;
        check_eq("wr_en", 64'(rf_wr_en), 64'(e_en));
        if (e_en) begin
            check_eq("wr_addr", 64'(rf_wr_addr), 64'(e_a));
            check_eq("wr_data", 64'(rf_wr_data), 64'(e_d));
        end
        if (rf_wr_en && watch_addr != 5'd0 && rf_wr_addr == watch_addr) begin
            watch_hits++;
            watch_data = rf_wr_data;
        end
        last_stall = was_force;
        if (!was_force) pipe_valid = 1'b0;
        if (acc) div_valid = 1'b0;
    endtask

    // Runs cycles until both requests have been taken, bounded.
    task automatic drain_inputs();
        int guard = 0;
        while ((pipe_valid || div_valid) && guard < 60) begin
            step();
            guard++;
        end
        if (guard >= 60) check_eq("bound", 64'(guard), 64'(0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pipe_busy();
        if (!pipe_valid) begin
            pipe_valid   = 1'b1;
            pipe_rd_addr = 5'd4;
            pipe_rd_data = $urandom;
        end
    endtask

    task automatic rand_inputs();
        if (!pipe_valid && ($urandom_range(0, 3) != 0)) begin
            pipe_valid   = 1'b1;
            pipe_rd_addr = 5'($urandom_range(0, 7));
            pipe_rd_data = $urandom;
        end
        if (!div_valid && ($urandom_range(0, 2) == 0)) begin
            div_valid   = 1'b1;
            div_rd_addr = 5'($urandom_range(0, 7));
            div_rd_data = $urandom;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pipe_valid = 1'b1; pipe_rd_addr = 5'($urandom_range(1, 7)); pipe_rd_data = $urandom;
            div_valid  = 1'b1; div_rd_addr  = 5'($urandom_range(1, 7)); div_rd_data  = $urandom;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        pipe_valid = 1'b0;
        div_valid  = 1'b0;
        model_reset();
        check_eq("rst_wr_en", 64'(rf_wr_en), 64'(0));
        check_eq("rst_wr_addr", 64'(rf_wr_addr), 64'(0));
        check_eq("rst_wr_data", 64'(rf_wr_data), 64'(0));
        check_eq("rst_stall", 64'(pipe_stall), 64'(0));
        check_eq("rst_ready", 64'(div_ready), 64'(1));
        check_eq("rst_mask", 64'(pend_mask), 64'(0));
    endtask

    initial begin
        int stalls;
        rst = 1'b1;
        pipe_valid = 1'b0; pipe_rd_addr = '0; pipe_rd_data = '0;
        div_valid  = 1'b0; div_rd_addr  = '0; div_rd_data  = '0;
        model_reset();
        do_reset();

        // pipe only: five back-to-back writes to x3
        for (int k = 0; k < 5; k++) begin
            pipe_valid = 1'b1; pipe_rd_addr = 5'd3; pipe_rd_data = 32'hA5;
            step();
            check_eq("pipe_en", 64'(rf_wr_en), 64'(1));
            check_eq("pipe_addr", 64'(rf_wr_addr), 64'(3));
            check_eq("pipe_data", 64'(rf_wr_data), 64'hA5);
            check_eq("pipe_nostall", 64'(pipe_stall), 64'(0));
        end
        idle(2);

        // divider into an idle port
        div_valid = 1'b1; div_rd_addr = 5'd7; div_rd_data = 32'h1234;
        step();
        check_eq("div_t1_en", 64'(rf_wr_en), 64'(BYP));
        check_eq("div_t1_mask7", 64'(pend_mask[7]), 64'(!BYP));
        step();
        if (!BYP) begin
            check_eq("div_t2_en", 64'(rf_wr_en), 64'(1));
            check_eq("div_t2_addr", 64'(rf_wr_addr), 64'(7));
            check_eq("div_t2_data", 64'(rf_wr_data), 64'h1234);
        end
        idle(2);

        // starvation: x9 waits behind a busy pipe until one forced drain
        stalls = 0;
        watch_addr = 5'd9; watch_hits = 0;
        div_valid = 1'b1; div_rd_addr = 5'd9; div_rd_data = 32'h9999;
        for (int k = 0; k < 10; k++) begin
            pipe_busy();
            step();
            if (last_stall) stalls++;
        end
        idle(3);
        check_eq("starve_stalls", 64'(stalls), 64'(1));
        check_eq("starve_x9_writes", 64'(watch_hits), 64'(1));

        // WAW kill: pending x5 superseded by a pipe write of 0x77
        watch_addr = 5'd5; watch_hits = 0;
        div_valid = 1'b1; div_rd_addr = 5'd5; div_rd_data = 32'hDEAD;
        pipe_valid = 1'b1; pipe_rd_addr = 5'd4; pipe_rd_data = 32'h44;
        step();
        check_eq("waw_mask_set", 64'(pend_mask[5]), 64'(1));
        pipe_valid = 1'b1; pipe_rd_addr = 5'd5; pipe_rd_data = 32'h77;
        step();
        check_eq("waw_mask_clr", 64'(pend_mask[5]), 64'(0));
        idle(4);
        check_eq("waw_x5_writes", 64'(watch_hits), 64'(1));
        check_eq("waw_x5_data", 64'(watch_data), 64'h77);
        watch_addr = 5'd0;

        // full FIFO behind a busy pipe, third result waits for a slot
        ready_low_seen = 0;
        for (int k = 0; k < 3; k++) begin
            int guard = 0;
            div_valid = 1'b1; div_rd_addr = 5'(10 + k); div_rd_data = 32'(32'h100 + k);
            while (div_valid && guard < 40) begin
                pipe_busy();
                step();
                guard++;
            end
            if (guard >= 40) check_eq("bound", 64'(guard), 64'(0));
        end
        drain_inputs();
        idle(4);
        check_eq("full_ready_low", 64'(ready_low_seen > 0), 64'(1));

        // random traffic with a reset in the middle
        for (int c = 0; c < 300; c++) begin
            rand_inputs();
            step();
        end
        do_reset();
        pipe_valid = 1'b1; pipe_rd_addr = 5'd2; pipe_rd_data = 32'hCAFE;
        step();
        check_eq("post_rst_addr", 64'(rf_wr_addr), 64'(2));
        for (int c = 0; c < 300; c++) begin
            rand_inputs();
            step();
        end
        drain_inputs();
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
